lsu_queued: RTL and testbench

LSU_QUEUED -- requirements
Module: lsu_queued

---
 rtl/lsu_queued.sv | 171 +++++++++++++++++
 tb/tb_lsu_queued.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_queued.sv
// Load/store unit: local scratchpad accesses go straight to DMEM, remote accesses
// queue in a small FIFO and issue under a credit limit; tracks one LR reservation.
module lsu_queued #(
  parameter int                      data_width_p      = 32,
  parameter int                      dmem_size_p       = 1024,
  parameter logic [data_width_p-1:0] spm_low_end_p     = data_width_p'(32'h03FF),
  parameter logic [data_width_p-1:0] spm_high_base_p   = data_width_p'(32'h1400),
  parameter logic [data_width_p-1:0] spm_high_end_p    = data_width_p'(32'h1FFF),
  parameter int                      req_fifo_els_p    = 4,
  parameter int                      max_out_credits_p = 16,
  localparam int dmem_addr_width_lp = $clog2(dmem_size_p),
  localparam int mask_width_lp      = data_width_p / 8,
  localparam int credit_width_lp    = $clog2(max_out_credits_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          exe_v_i,
  input  logic                          is_load_i,
  input  logic                          is_store_i,
  input  logic                          is_lr_i,
  input  logic                          is_byte_i,
  input  logic                          is_hex_i,
  input  logic                          is_unsigned_i,
  input  logic [data_width_p-1:0]       rs1_i,
  input  logic [data_width_p-1:0]       rs2_i,
  input  logic [data_width_p-1:0]       offset_i,
  input  logic                          fence_i,
  input  logic                          credit_return_i,
  input  logic                          remote_ready_i,
  output logic                          stall_o,
  output logic                          err_o,
  output logic                          dmem_v_o,
  output logic                          dmem_w_o,
  output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
  output logic [data_width_p-1:0]       dmem_data_o,
  output logic [mask_width_lp-1:0]      dmem_mask_o,
  output logic                          remote_v_o,
  output logic                          remote_w_o,
  output logic [data_width_p-1:0]       remote_addr_o,
  output logic [data_width_p-1:0]       remote_data_o,
  output logic [mask_width_lp-1:0]      remote_mask_o,
  output logic [4:0]                    remote_info_o,
  output logic [credit_width_lp-1:0]    credits_o,
  output logic                          reserve_v_o,
  output logic [dmem_addr_width_lp-1:0] reserve_addr_o,
  output logic                          credit_err_o
);

  localparam int ptr_width_lp = (req_fifo_els_p > 1) ? $clog2(req_fifo_els_p) : 1;
  localparam int cnt_width_lp = $clog2(req_fifo_els_p + 1);
  localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(max_out_credits_p);
  localparam logic [cnt_width_lp-1:0]    fifo_full_lp   = cnt_width_lp'(req_fifo_els_p);

  typedef struct packed {
    logic                     w;
    logic [data_width_p-1:0]  addr;
    logic [data_width_p-1:0]  data;
    logic [mask_width_lp-1:0] mask;
    logic [4:0]               info;
  } req_s;

  logic [data_width_p-1:0]  addr;
  logic [data_width_p-1:0]  store_data;
  logic [mask_width_lp-1:0] store_mask;
  logic is_local, is_word, misaligned, mem_op, err, would_enq, stall, enq, deq;
  logic fifo_empty, fifo_full;

  req_s                    fifo_mem [req_fifo_els_p];
  req_s                    enq_req, head;
  logic [ptr_width_lp-1:0] rd_ptr, wr_ptr;
  logic [cnt_width_lp-1:0] count;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(req_fifo_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign addr       = rs1_i + offset_i;
  assign is_local   = (addr <= spm_low_end_p) ||
                      ((addr >= spm_high_base_p) && (addr <= spm_high_end_p));
  assign is_word    = ~is_byte_i & ~is_hex_i;
  assign misaligned = (is_hex_i & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  assign mem_op     = is_load_i | is_store_i | is_lr_i;
  assign err        = exe_v_i & mem_op & (misaligned | (is_lr_i & ~is_local));
  assign would_enq  = exe_v_i & (is_load_i | is_store_i) & ~is_local & ~err;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == fifo_full_lp);

  // A dequeue in the same cycle does not free a slot for the stalled op.
  assign stall = (would_enq & fifo_full) |
                 (fence_i & (~fifo_empty | (credits_o != credits_max_lp)));

  assign stall_o  = ~reset_i & stall;
  assign err_o    = ~reset_i & err;
  assign dmem_v_o = ~reset_i & exe_v_i & ~stall & ~err & is_local & mem_op;
  assign enq      = would_enq & ~stall;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    store_data = rs2_i;
    store_mask = '1;
    if (is_byte_i) begin
      store_data = {(data_width_p/8){rs2_i[7:0]}};
      store_mask = mask_width_lp'(1) << addr[1:0];
    end else if (is_hex_i) begin
      store_data = {(data_width_p/16){rs2_i[15:0]}};
      store_mask = mask_width_lp'(3) << {addr[1], 1'b0};
    end
  end

  assign dmem_w_o    = is_store_i;
  assign dmem_addr_o = addr[2 +: dmem_addr_width_lp];
  assign dmem_data_o = store_data;
  assign dmem_mask_o = store_mask;

  assign enq_req = '{w: is_store_i, addr: addr, data: store_data, mask: store_mask,
                     info: {is_unsigned_i, is_byte_i, is_hex_i, addr[1:0]}};

  assign head          = fifo_mem[rd_ptr];
  assign remote_v_o    = ~fifo_empty & (credits_o != '0);
  assign remote_w_o    = head.w;
  assign remote_addr_o = head.addr;
  assign remote_data_o = head.data;
  assign remote_mask_o = head.mask;
  assign remote_info_o = head.info;
  assign deq           = remote_v_o & remote_ready_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= next_ptr(wr_ptr);
      if (deq) rd_ptr <= next_ptr(rd_ptr);
      if (enq & ~deq)      count <= count + cnt_width_lp'(1);
      else if (deq & ~enq) count <= count - cnt_width_lp'(1);
    end
  end

  // NOTE: the FIFO storage has no reset; validity is carried entirely by count, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem[wr_ptr] <= enq_req;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_o    <= credits_max_lp;
      credit_err_o <= 1'b0;
    end else if (deq & ~credit_return_i) begin
      credits_o <= credits_o - credit_width_lp'(1);
    end else if (credit_return_i & ~deq) begin
      if (credits_o == credits_max_lp) credit_err_o <= 1'b1;
      else                             credits_o    <= credits_o + credit_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      reserve_v_o    <= 1'b0;
      reserve_addr_o <= '0;
    end else if (dmem_v_o & is_lr_i) begin
      reserve_v_o    <= 1'b1;
      reserve_addr_o <= dmem_addr_o;
    end else if (dmem_v_o & is_store_i & reserve_v_o & (dmem_addr_o == reserve_addr_o)) begin
      reserve_v_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_queued.sv
// Randomized bench for lsu_queued: a request-level model predicts local accesses
// and pushes expected remote requests into a scoreboard checked by a monitor.
module tb_lsu_queued;

  localparam int DW  = 32;
  localparam int DSZ = 2048;
  localparam int AW  = 11;
  localparam int ELS = 4;
  localparam int MC  = 2;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          exe_v_i, is_load_i, is_store_i, is_lr_i, is_byte_i, is_hex_i, is_unsigned_i;
  logic [DW-1:0] rs1_i, rs2_i, offset_i;
  logic          fence_i, credit_return_i, remote_ready_i;
  logic          stall_o, err_o, dmem_v_o, dmem_w_o;
  logic [AW-1:0] dmem_addr_o, reserve_addr_o;
  logic [DW-1:0] dmem_data_o, remote_addr_o, remote_data_o;
  logic [3:0]    dmem_mask_o, remote_mask_o;
  logic          remote_v_o, remote_w_o, reserve_v_o, credit_err_o;
  logic [4:0]    remote_info_o;
  logic [CW-1:0] credits_o;

  lsu_queued #(
    .data_width_p(DW), .dmem_size_p(DSZ), .req_fifo_els_p(ELS), .max_out_credits_p(MC)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .exe_v_i(exe_v_i), .is_load_i(is_load_i),
    .is_store_i(is_store_i), .is_lr_i(is_lr_i), .is_byte_i(is_byte_i), .is_hex_i(is_hex_i),
    .is_unsigned_i(is_unsigned_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .offset_i(offset_i),
    .fence_i(fence_i), .credit_return_i(credit_return_i), .remote_ready_i(remote_ready_i),
    .stall_o(stall_o), .err_o(err_o), .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o),
    .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o), .dmem_mask_o(dmem_mask_o),
    .remote_v_o(remote_v_o), .remote_w_o(remote_w_o), .remote_addr_o(remote_addr_o),
    .remote_data_o(remote_data_o), .remote_mask_o(remote_mask_o), .remote_info_o(remote_info_o),
    .credits_o(credits_o), .reserve_v_o(reserve_v_o), .reserve_addr_o(reserve_addr_o),
    .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, ld, st, lr, byt, hex, uns, fence, cret, cret_force, rready;
    logic [31:0] rs1, rs2, off;
  } op_t;

  typedef struct packed {
    logic        w;
    logic [31:0] addr, data;
    logic [3:0]  mask;
    logic [4:0]  info;
  } req_t;

  int   total = 0;
  int   bad   = 0;
  req_t exp_q[$];
  int   m_credits = MC;
  bit   m_cerr    = 1'b0;
  bit   m_res_v   = 1'b0;
  int   m_res_a   = 0;
  bit   have_push = 1'b0;
  req_t push_req;
  bit   res_set = 1'b0, res_clr = 1'b0;
  int   res_a = 0;
  op_t  nx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t idle();
    op_t o;
    o = '0;
    return o;
  endfunction

  // kind: 0 load, 1 store, 2 lr; size: 0 byte, 1 hex, 2 word
  function automatic op_t mk(input int kind, input int size, input logic [31:0] rs1,
                             input logic [31:0] off, input logic [31:0] rs2);
    op_t o;
    o     = '0;
    o.v   = 1'b1;
    o.ld  = (kind == 0);
    o.st  = (kind == 1);
    o.lr  = (kind == 2);
    o.byt = (size == 0);
    o.hex = (size == 1);
    o.rs1 = rs1;
    o.off = off;
    o.rs2 = rs2;
    return o;
  endfunction

  function automatic bit in_local(input logic [31:0] a);
    return (a <= 32'h3FF) || (a >= 32'h1400 && a <= 32'h1FFF);
  endfunction

  // One clock: apply last cycle's model effects, drive nx, then predict and check.
  task automatic cycle(output bit stalled);
    logic [31:0] a, sd;
    logic [3:0]  sm;
    bit loc, mem, word, mis, err, wenq, e_stall, e_dv;
    int wa;
    @(posedge clk);
    if (have_push) exp_q.push_back(push_req);
    have_push = 1'b0;
    if (res_set) begin m_res_v = 1'b1; m_res_a = res_a; end
    if (res_clr) m_res_v = 1'b0;
    res_set = 1'b0;
    res_clr = 1'b0;
    #1;
    exe_v_i = nx.v; is_load_i = nx.ld; is_store_i = nx.st; is_lr_i = nx.lr;
    is_byte_i = nx.byt; is_hex_i = nx.hex; is_unsigned_i = nx.uns;
    rs1_i = nx.rs1; rs2_i = nx.rs2; offset_i = nx.off;
    fence_i = nx.fence; remote_ready_i = nx.rready;
    credit_return_i = nx.cret_force | (nx.cret & (m_credits < MC));
    #3;
    a    = nx.rs1 + nx.off;
    loc  = in_local(a);
    mem  = nx.ld || nx.st || nx.lr;
    word = !nx.byt && !nx.hex;
    mis  = (nx.hex && (a % 2 != 0)) || (word && (a % 4 != 0));
    err  = nx.v && mem && (mis || (nx.lr && !loc));
    wenq = nx.v && (nx.ld || nx.st) && !loc && !err;
    e_stall = (wenq && exp_q.size() == ELS) ||
              (nx.fence && (exp_q.size() != 0 || m_credits != MC));
    e_dv = nx.v && !e_stall && !err && loc && mem;
    wa   = int'((a / 4) % DSZ);
    if (nx.byt) begin
      sd = {24'h0, nx.rs2[7:0]} * 32'h0101_0101;
      sm = 4'(1 << (a % 4));
    end else if (nx.hex) begin
      sd = {16'h0, nx.rs2[15:0]} * 32'h0001_0001;
      sm = (a % 4 >= 2) ? 4'hC : 4'h3;
    end else begin
      sd = nx.rs2;
      sm = 4'hF;
    end
    check("err_o", err_o, err);
    check("stall_o", stall_o, e_stall);
    check("dmem_v_o", dmem_v_o, e_dv);
    if (e_dv) begin
      check("dmem_w_o", dmem_w_o, nx.st);
      check("dmem_addr_o", dmem_addr_o, wa);
      if (nx.st) begin
        check("dmem_data_o", dmem_data_o, sd);
        check("dmem_mask_o", dmem_mask_o, sm);
      end
    end
    check("reserve_v_o", reserve_v_o, m_res_v);
    check("reserve_addr_o", reserve_addr_o, m_res_a);
    if (wenq && !e_stall) begin
      have_push = 1'b1;
      push_req  = '{w: nx.st, addr: a, data: sd, mask: sm,
                    info: {nx.uns, nx.byt, nx.hex, a[1:0]}};
    end
    if (e_dv && nx.lr) begin
      res_set = 1'b1;
      res_a   = wa;
    end else if (e_dv && nx.st && m_res_v && m_res_a == wa) begin
      res_clr = 1'b1;
    end
    stalled = e_stall;
  endtask

  task automatic issue(input op_t o, input int budget);
    bit st;
    int n;
    nx = o;
    n  = 0;
    do begin cycle(st); n++; end while (st && n < budget);
    if (st) begin
      total++; bad++;
      $display("FAIL issue_timeout: stalled for %0d cycles, want accepted", n);
    end
  endtask

  task automatic drain();
    bit st;
    int n;
    nx = idle();
    nx.rready = 1'b1;
    nx.cret   = 1'b1;
    nx.fence  = 1'b1;
    n = 0;
    do begin cycle(st); n++; end while (st && n < 200);
    if (st) begin
      total++; bad++;
      $display("FAIL drain_timeout: fence still stalled after %0d cycles", n);
    end
    nx = idle();
    cycle(st);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_i = 1'b1;
    #1;
    check("rst_remote_v", remote_v_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_dmem_v", dmem_v_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_credits", credits_o, MC);
    check("rst_credit_err", credit_err_o, 1'b0);
    check("rst_reserve_v", reserve_v_o, 1'b0);
    check("rst_reserve_addr", reserve_addr_o, 0);
    have_push = 1'b0;
    res_set = 1'b0; res_clr = 1'b0;
    m_res_v = 1'b0; m_res_a = 0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  // Monitor: owns the credit model and pops the scoreboard on each handshake.
  initial begin
    bit   e_rv, deq;
    req_t h;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        exp_q.delete();
        m_credits = MC;
        m_cerr    = 1'b0;
        check("rst_remote_v_mon", remote_v_o, 1'b0);
      end else begin
        e_rv = (exp_q.size() > 0) && (m_credits > 0);
        check("remote_v_o", remote_v_o, e_rv);
        check("credits_o", credits_o, m_credits);
        check("credit_err_o", credit_err_o, m_cerr);
        if (e_rv && remote_v_o) begin
          h = exp_q[0];
          check("remote_w_o", remote_w_o, h.w);
          check("remote_addr_o", remote_addr_o, h.addr);
          check("remote_info_o", remote_info_o, h.info);
          if (h.w) begin
            check("remote_data_o", remote_data_o, h.data);
            check("remote_mask_o", remote_mask_o, h.mask);
          end
        end
        deq = e_rv && remote_ready_i;
        if (deq) h = exp_q.pop_front();
        if (deq && !credit_return_i) m_credits--;
        else if (credit_return_i && !deq) begin
          if (m_credits == MC) m_cerr = 1'b1;
          else                 m_credits++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          st;
    op_t         o;
    logic [31:0] a, bnd[7];
    int          size;

    // Reset with an op that would otherwise raise err_o.
    reset_i = 1'b1;
    nx = mk(2, 2, 32'h8000_0000, 0, 0);
    exe_v_i = 1'b1; is_load_i = 1'b0; is_store_i = 1'b0; is_lr_i = 1'b1;
    is_byte_i = 1'b0; is_hex_i = 1'b0; is_unsigned_i = 1'b0;
    rs1_i = 32'h8000_0000; rs2_i = '0; offset_i = '0;
    fence_i = 1'b1; credit_return_i = 1'b0; remote_ready_i = 1'b0;
    #3;
    check("init_err", err_o, 1'b0);
    check("init_stall", stall_o, 1'b0);
    check("init_dmem_v", dmem_v_o, 1'b0);
    check("init_remote_v", remote_v_o, 1'b0);
    check("init_credits", credits_o, MC);
    check("init_reserve_v", reserve_v_o, 1'b0);
    check("init_credit_err", credit_err_o, 1'b0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Local byte store into the high window.
    issue(mk(1, 0, 32'h1400, 3, 32'hAB), 2);
    check("req022_addr", dmem_addr_o, 11'h500);
    check("req022_data", dmem_data_o, 32'hABAB_ABAB);
    check("req022_mask", dmem_mask_o, 4'b1000);
    issue(mk(1, 1, 32'h0100, 2, 32'h1234_BEEF), 2);
    issue(mk(0, 2, 32'h1FF0, 12, 0), 2);

    // Reservation set, survives a store to another word, cleared by a matching store.
    issue(mk(2, 2, 32'h0010, 0, 0), 2);
    issue(mk(1, 2, 32'h0014, 0, 32'h5), 2);
    check("req025_res_v", reserve_v_o, 1'b1);
    check("req025_res_addr", reserve_addr_o, 4);
    issue(mk(1, 2, 32'h0010, 0, 32'h6), 2);
    nx = idle();
    cycle(st);
    check("req025_res_clr", reserve_v_o, 1'b0);

    // Misaligned word load and remote LR both error.
    issue(mk(0, 2, 32'h1402, 0, 0), 2);
    issue(mk(2, 2, 32'h8000_0000, 0, 0), 2);

    // Fill the FIFO with the network blocked; fifth op stalls.
    for (int i = 0; i < 4; i++) issue(mk(0, 2, 32'h8000_0000, 0, 0), 2);
    nx = mk(0, 2, 32'h8000_0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(st);
      check("req023_full_stall", stall_o, 1'b1);
    end
    nx.rready = 1'b1;
    cycle(st);
    check("req023_same_cycle_stall", stall_o, 1'b1);
    cycle(st);
    check("req023_released", stall_o, 1'b0);
    drain();

    // Credit exhaustion, return, then simultaneous dequeue and return.
    for (int i = 0; i < 3; i++) begin
      o = mk(1, 2, 32'h8000_0100 + 32'(4 * i), 0, 32'hC0DE_0000 + 32'(i));
      o.rready = 1'b1;
      issue(o, 2);
    end
    nx = idle();
    nx.rready = 1'b1;
    repeat (4) cycle(st);
    check("req024_credits_zero", credits_o, 0);
    check("req024_third_waits", remote_v_o, 1'b1 && 1'b0);
    nx.cret = 1'b1;
    cycle(st);
    nx.cret = 1'b0;
    cycle(st);
    check("req024_third_issued", remote_v_o, 1'b1);
    o = mk(1, 2, 32'h8000_0200, 0, 32'h77);
    o.rready = 1'b1;
    o.cret   = 1'b1;
    issue(o, 2);
    nx = idle();
    nx.rready = 1'b1;
    nx.cret   = 1'b1;
    cycle(st);
    nx = idle();
    cycle(st);
    check("req024_simul_hold", credits_o, 1);
    drain();

    // Credit overflow is sticky until reset.
    nx = idle();
    nx.cret_force = 1'b1;
    cycle(st);
    nx = idle();
    cycle(st);
    check("req026_credit_err", credit_err_o, 1'b1);
    cycle(st);
    check("req026_credit_err_sticky", credit_err_o, 1'b1);
    do_reset();

    // Reset while requests are queued.
    issue(mk(0, 2, 32'h9000_0000, 0, 0), 2);
    issue(mk(1, 0, 32'h9000_0001, 0, 32'h42), 2);
    nx = idle();
    cycle(st);
    check("pre_reset_remote_v", remote_v_o, 1'b1);
    do_reset();

    // Randomized traffic.
    bnd = '{32'h3FF, 32'h400, 32'h13FF, 32'h1400, 32'h1FFF, 32'h2000, 32'hFFFF_FFFC};
    for (int n = 0; n < 800; n++) begin
      size = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 32'h3FF);
        1:       a = $urandom_range(32'h1400, 32'h1FFF);
        2:       a = $urandom_range(32'h2000, 32'hFFFF_FFF0);
        default: a = bnd[$urandom_range(0, 6)];
      endcase
      if ($urandom_range(0, 4) != 0) begin
        if (size == 1) a[0] = 1'b0;
        if (size == 2) a[1:0] = 2'b00;
      end
      o = mk($urandom_range(0, 2), size, $urandom, 0, $urandom);
      o.off    = a - o.rs1;
      o.v      = ($urandom_range(0, 9) < 7);
      o.uns    = $urandom_range(0, 1);
      o.fence  = ($urandom_range(0, 15) == 0);
      o.rready = ($urandom_range(0, 3) != 0);
      o.cret   = ($urandom_range(0, 2) == 0);
      nx = o;
      cycle(st);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
